// File: rtl/data_bus_bridge_pkg.sv
// rtl/data_bus_bridge_pkg.sv - shared types and constants for the data bus bridge
package data_bus_bridge_pkg;

   localparam int XLEN = 32;

   typedef enum logic [1:0] {
      MS_B = 2'd0,
      MS_H = 2'd1,
      MS_W = 2'd2
   } mem_size_e;

   typedef enum logic [1:0] {
      BS_IDLE = 2'd0,
      BS_REQ  = 2'd1,
      BS_RESP = 2'd2,
      BS_DONE = 2'd3
   } bus_state_e;

   localparam logic [3:0] BE_BYTE = 4'b0001;
   localparam logic [3:0] BE_HALF = 4'b0011;
   localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/byte_lane_aligner.sv
// rtl/byte_lane_aligner.sv - byte-lane placement of store data/enables and lane-0 return of load data
module byte_lane_aligner
   import data_bus_bridge_pkg::*;
(
   input  logic [1:0]      size_i,
   input  logic [1:0]      off_i,
   input  logic [1:0]      rd_off_i,
   input  logic [XLEN-1:0] wdata_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [3:0]      be_o,
   output logic [XLEN-1:0] wdata_o,
   output logic [XLEN-1:0] rdata_o,
   output logic            misaligned_o
);

   // size 3 falls through to the defaults: no lanes, flagged misaligned
   always_comb begin
      be_o         = 4'b0000;
      misaligned_o = 1'b1;
      case (mem_size_e'(size_i))
         MS_B: begin
            be_o         = BE_BYTE << off_i;
            misaligned_o = 1'b0;
         end
         MS_H: begin
            be_o         = BE_HALF << off_i;
            misaligned_o = off_i[0];
         end
         MS_W: begin
            be_o         = BE_WORD << off_i;
            misaligned_o = |off_i;
         end
         default: ;
      endcase
   end

   assign wdata_o = wdata_i << {off_i, 3'b000};
   assign rdata_o = rdata_i >> {rd_off_i, 3'b000};

endmodule

// File: rtl/data_bus_bridge.sv
// rtl/data_bus_bridge.sv - core-to-data-bus bridge running the req/gnt/rvalid handshake
module data_bus_bridge
   import data_bus_bridge_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_ni,
   input  logic            req_valid_i,
   input  logic            we_i,
   input  logic [1:0]      size_i,
   input  logic [XLEN-1:0] addr_i,
   input  logic [XLEN-1:0] wdata_i,
   output logic [XLEN-1:0] rdata_o,
   output logic            stall_o,
   output logic            misaligned_o,
   output logic            bus_req_o,
   input  logic            bus_gnt_i,
   output logic [XLEN-1:0] bus_addr_o,
   output logic            bus_we_o,
   output logic [3:0]      bus_be_o,
   output logic [XLEN-1:0] bus_wdata_o,
   input  logic            bus_rvalid_i,
   input  logic [XLEN-1:0] bus_rdata_i
);

   bus_state_e      state_q;
   logic [1:0]      off_q;
   logic [XLEN-1:0] rdata_q;
   logic            bus_req_q;
   logic [XLEN-1:0] bus_addr_q;
   logic            bus_we_q;
   logic [3:0]      bus_be_q;
   logic [XLEN-1:0] bus_wdata_q;

   logic [3:0]      be_d;
   logic [XLEN-1:0] wdata_d;
   logic [XLEN-1:0] rdata_d;
   logic            mis;
   logic            accept;

   byte_lane_aligner u_aligner (
      .size_i       (size_i),
      .off_i        (addr_i[1:0]),
      .rd_off_i     (off_q),
      .wdata_i      (wdata_i),
      .rdata_i      (bus_rdata_i),
      .be_o         (be_d),
      .wdata_o      (wdata_d),
      .rdata_o      (rdata_d),
      .misaligned_o (mis)
   );

   assign accept       = (state_q == BS_IDLE) & req_valid_i & ~mis;
   assign misaligned_o = (state_q == BS_IDLE) & req_valid_i & mis;
   assign stall_o      = accept | (state_q == BS_REQ) | (state_q == BS_RESP);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= BS_IDLE;
         off_q       <= 2'b00;
         rdata_q     <= '0;
         bus_req_q   <= 1'b0;
         bus_addr_q  <= '0;
         bus_we_q    <= 1'b0;
         bus_be_q    <= 4'b0000;
         bus_wdata_q <= '0;
      end else begin
         case (state_q)
            BS_IDLE: begin
               if (accept) begin
                  state_q     <= BS_REQ;
                  bus_req_q   <= 1'b1;
                  bus_addr_q  <= {addr_i[XLEN-1:2], 2'b00};
                  bus_we_q    <= we_i;
                  bus_be_q    <= be_d;
                  bus_wdata_q <= wdata_d;
                  off_q       <= addr_i[1:0];
               end
            end
            BS_REQ: begin
               if (bus_gnt_i) begin
                  state_q   <= BS_RESP;
                  bus_req_q <= 1'b0;
               end
            end
            BS_RESP: begin
               if (bus_rvalid_i) begin
                  state_q <= BS_DONE;
                  if (!bus_we_q) rdata_q <= rdata_d;
               end
            end
            default: state_q <= BS_IDLE;
         endcase
      end
   end

   assign rdata_o     = rdata_q;
   assign bus_req_o   = bus_req_q;
   assign bus_addr_o  = bus_addr_q;
   assign bus_we_o    = bus_we_q;
   assign bus_be_o    = bus_be_q;
   assign bus_wdata_o = bus_wdata_q;

endmodule

// File: tb/tb_data_bus_bridge.sv
// tb/tb_data_bus_bridge.sv - directed self-checking bench for data_bus_bridge
module tb_data_bus_bridge;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic        req_valid_i;
   logic        we_i;
   logic [1:0]  size_i;
   logic [31:0] addr_i;
   logic [31:0] wdata_i;
   logic [31:0] rdata_o;
   logic        stall_o;
   logic        misaligned_o;
   logic        bus_req_o;
   logic        bus_gnt_i;
   logic [31:0] bus_addr_o;
   logic        bus_we_o;
   logic [3:0]  bus_be_o;
   logic [31:0] bus_wdata_o;
   logic        bus_rvalid_i;
   logic [31:0] bus_rdata_i;

   int checks   = 0;
   int failures = 0;

   data_bus_bridge dut (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .req_valid_i  (req_valid_i),
      .we_i         (we_i),
      .size_i       (size_i),
      .addr_i       (addr_i),
      .wdata_i      (wdata_i),
      .rdata_o      (rdata_o),
      .stall_o      (stall_o),
      .misaligned_o (misaligned_o),
      .bus_req_o    (bus_req_o),
      .bus_gnt_i    (bus_gnt_i),
      .bus_addr_o   (bus_addr_o),
      .bus_we_o     (bus_we_o),
      .bus_be_o     (bus_be_o),
      .bus_wdata_o  (bus_wdata_o),
      .bus_rvalid_i (bus_rvalid_i),
      .bus_rdata_i  (bus_rdata_i)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s act=0x%08h exp=0x%08h", tag, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk_i);
      #1;
   endtask

   task automatic check_req_fields(input string tag, input logic we, input logic [31:0] ea,
                                   input logic [3:0] ebe, input logic [31:0] ewd);
      check_eq({tag, ".req"},   {31'd0, bus_req_o}, 32'd1);
      check_eq({tag, ".addr"},  bus_addr_o, ea);
      check_eq({tag, ".we"},    {31'd0, bus_we_o}, {31'd0, we});
      check_eq({tag, ".be"},    {28'd0, bus_be_o}, {28'd0, ebe});
      check_eq({tag, ".wdata"}, bus_wdata_o, ewd);
      check_eq({tag, ".stall"}, {31'd0, stall_o}, 32'd1);
   endtask

   // Called at posedge+1 of an IDLE cycle; returns at posedge+1 of the following IDLE cycle.
   task automatic access(input string tag, input logic we, input logic [1:0] sz,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] brd,
                         input int gdly, input int rdly,
                         input logic [31:0] ea, input logic [3:0] ebe,
                         input logic [31:0] ewd, input logic [31:0] erd);
      req_valid_i = 1'b1;
      we_i        = we;
      size_i      = sz;
      addr_i      = a;
      wdata_i     = wd;
      bus_gnt_i   = 1'b0;
      bus_rvalid_i = 1'b0;
      @(negedge clk_i);
      check_eq({tag, ".idle_stall"}, {31'd0, stall_o}, 32'd1);
      check_eq({tag, ".idle_mis"},   {31'd0, misaligned_o}, 32'd0);
      check_eq({tag, ".idle_req"},   {31'd0, bus_req_o}, 32'd0);
      next_cycle();
      for (int i = 0; i < gdly; i++) begin
         @(negedge clk_i);
         check_req_fields({tag, ".wait"}, we, ea, ebe, ewd);
         next_cycle();
      end
      bus_gnt_i = 1'b1;
      @(negedge clk_i);
      check_req_fields({tag, ".gnt"}, we, ea, ebe, ewd);
      next_cycle();
      bus_gnt_i = 1'b0;
      for (int i = 0; i < rdly; i++) begin
         @(negedge clk_i);
         check_eq({tag, ".resp_stall"}, {31'd0, stall_o}, 32'd1);
         check_eq({tag, ".resp_req"},   {31'd0, bus_req_o}, 32'd0);
         next_cycle();
      end
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = brd;
      @(negedge clk_i);
      check_eq({tag, ".rv_stall"}, {31'd0, stall_o}, 32'd1);
      check_eq({tag, ".rv_req"},   {31'd0, bus_req_o}, 32'd0);
      next_cycle();
      bus_rvalid_i = 1'b0;
      @(negedge clk_i);
      check_eq({tag, ".done_stall"}, {31'd0, stall_o}, 32'd0);
      check_eq({tag, ".done_rdata"}, rdata_o, erd);
      next_cycle();
   endtask

   task automatic misaligned_case(input string tag, input logic we, input logic [1:0] sz,
                                  input logic [31:0] a);
      req_valid_i = 1'b1;
      we_i        = we;
      size_i      = sz;
      addr_i      = a;
      bus_gnt_i   = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check_eq({tag, ".mis"},   {31'd0, misaligned_o}, 32'd1);
         check_eq({tag, ".stall"}, {31'd0, stall_o}, 32'd0);
         check_eq({tag, ".req"},   {31'd0, bus_req_o}, 32'd0);
         next_cycle();
      end
      req_valid_i = 1'b0;
      bus_gnt_i   = 1'b0;
      @(negedge clk_i);
      check_eq({tag, ".mis_clr"}, {31'd0, misaligned_o}, 32'd0);
      next_cycle();
   endtask

   initial begin
      rst_ni       = 1'b0;
      req_valid_i  = 1'b0;
      we_i         = 1'b0;
      size_i       = 2'd0;
      addr_i       = 32'd0;
      wdata_i      = 32'd0;
      bus_gnt_i    = 1'b0;
      bus_rvalid_i = 1'b0;
      bus_rdata_i  = 32'd0;
      repeat (2) next_cycle();
      @(negedge clk_i);
      check_eq("rst.rdata", rdata_o, 32'd0);
      check_eq("rst.addr",  bus_addr_o, 32'd0);
      check_eq("rst.wdata", bus_wdata_o, 32'd0);
      check_eq("rst.be",    {28'd0, bus_be_o}, 32'd0);
      check_eq("rst.req",   {31'd0, bus_req_o}, 32'd0);
      check_eq("rst.we",    {31'd0, bus_we_o}, 32'd0);
      check_eq("rst.stall", {31'd0, stall_o}, 32'd0);
      next_cycle();
      rst_ni = 1'b1;
      next_cycle();

      access("sb",  1'b1, 2'd0, 32'h0000_1003, 32'h0000_00AB, 32'h0, 0, 0,
             32'h0000_1000, 4'b1000, 32'hAB00_0000, 32'h0);
      req_valid_i = 1'b0;
      next_cycle();

      access("lh",  1'b0, 2'd1, 32'h0000_2002, 32'h0000_BEEF, 32'h8765_4321, 0, 0,
             32'h0000_2000, 4'b1100, 32'hBEEF_0000, 32'h0000_8765);
      req_valid_i = 1'b0;
      next_cycle();

      access("lw_slow", 1'b0, 2'd2, 32'h0000_3000, 32'h1357_9BDF, 32'hDEAD_BEEF, 3, 2,
             32'h0000_3000, 4'b1111, 32'h1357_9BDF, 32'hDEAD_BEEF);
      req_valid_i = 1'b0;
      next_cycle();

      misaligned_case("lw_mis", 1'b0, 2'd2, 32'h0000_3002);
      misaligned_case("sh_mis", 1'b1, 2'd1, 32'h0000_0001);
      misaligned_case("sz3_mis", 1'b0, 2'd3, 32'h0000_0000);

      access("sw0", 1'b1, 2'd2, 32'h0000_0010, 32'h1122_3344, 32'h0, 0, 0,
             32'h0000_0010, 4'b1111, 32'h1122_3344, 32'hDEAD_BEEF);
      access("sw1", 1'b1, 2'd2, 32'h0000_0014, 32'h5566_7788, 32'h0, 0, 0,
             32'h0000_0014, 4'b1111, 32'h5566_7788, 32'hDEAD_BEEF);
      req_valid_i = 1'b0;
      next_cycle();

      // Reset in RESP, then a stray rvalid once reset is released
      req_valid_i = 1'b1;
      we_i        = 1'b0;
      size_i      = 2'd2;
      addr_i      = 32'h0000_0040;
      bus_gnt_i   = 1'b1;
      next_cycle();
      next_cycle();
      bus_gnt_i   = 1'b0;
      req_valid_i = 1'b0;
      @(negedge clk_i);
      check_eq("rrst.pre_stall", {31'd0, stall_o}, 32'd1);
      check_eq("rrst.pre_req",   {31'd0, bus_req_o}, 32'd0);
      rst_ni = 1'b0;
      #1;
      check_eq("rrst.stall", {31'd0, stall_o}, 32'd0);
      check_eq("rrst.rdata", rdata_o, 32'd0);
      check_eq("rrst.req",   {31'd0, bus_req_o}, 32'd0);
      next_cycle();
      rst_ni       = 1'b1;
      bus_rvalid_i = 1'b1;
      bus_rdata_i  = 32'hFFFF_FFFF;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         check_eq("rrst.late_stall", {31'd0, stall_o}, 32'd0);
         check_eq("rrst.late_req",   {31'd0, bus_req_o}, 32'd0);
         check_eq("rrst.late_rdata", rdata_o, 32'd0);
         next_cycle();
      end
      bus_rvalid_i = 1'b0;

      access("post_rst", 1'b0, 2'd0, 32'h0000_0051, 32'h0, 32'h0000_C300, 0, 0,
             32'h0000_0050, 4'b0010, 32'h0, 32'h0000_00C3);
      req_valid_i = 1'b0;
      next_cycle();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
